// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states
// and the alignment/legality rule applied when a request is accepted.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        ERR   = 3'd3,
        RESP  = 3'd4
    } state_e;

    // True when the size code is legal and the byte offset is naturally aligned.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = !offset[0];
            SZ_WORD: ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane steering: extracts and extends sub-word load data from a
// memory word, and merges sub-word store data into it.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
                case (offset_i)
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    2'd3:    merge_o[31:24] = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & half_sel[15]}}, half_sel};
                if (offset_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: merge_o = wdata_i;
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts byte/half/word load-store requests into word-only memory accesses,
// using read-modify-write for sub-word stores and rejecting bad requests.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic        range_err;
    logic        acc_err;

    always_comb begin
        range_err = CHECK_RANGE && ({2'b00, req_addr[31:2]} >= MEM_WORDS);
        acc_err   = range_err || !access_legal(req_size, req_addr[1:0]);
    end

    byte_lane_unit u_lanes (
        .word_i   (mem_rd),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_d),
        .merge_o  (merge_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        if (acc_err) begin
                            state_q <= ERR;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        merge_q <= merge_d;
                        state_q <= WRITE;
                    end else begin
                        resp_rdata_q <= load_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                ERR: begin
                    resp_err_q   <= 1'b1;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    // Response fields are only meaningful while resp_valid is high.
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write enable is gated by reset so a reset landing on WRITE cancels the store.
    assign mem_we     = (state_q == WRITE) && !reset;
    assign mem_wd     = (state_q == WRITE) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : 32'h0;
    assign mem_addr   = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized requests
// checked against an arithmetic model of memory and load/store results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MEM_WORDS   (1024),
        .CHECK_RANGE (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Small attached memory; higher address bits alias onto these 16 words.
    assign mem_rd = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wd;
        else if (pre_en) mem[pre_idx] <= pre_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // One request, modelled from the rules: error predicate, latency table,
    // shift/mask extraction and masked merge into the reference memory.
    task automatic do_op(input string tag, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got_rd, output logic got_err);
        logic        e;
        int          lat, exp_we, sh, resp_cyc, we_cyc, we_cnt, resp_cnt;
        logic [31:0] idx, w, mask, exp_rd;

        idx    = addr >> 2;
        e      = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
                 || (idx >= 32'd1024);
        lat    = 2;
        exp_we = 0;
        exp_rd = 32'h0;
        if (!e) begin
            w = ref_mem[idx[3:0]];
            if (sz == 2'd2) begin mask = 32'hFFFF_FFFF; sh = 0; end
            else if (sz == 2'd1) begin mask = 32'h0000_FFFF; sh = 32'(addr & 32'd2) * 8; end
            else begin mask = 32'h0000_00FF; sh = 32'(addr & 32'd3) * 8; end
            if (we) begin
                ref_mem[idx[3:0]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
                exp_we = 1;
                lat    = (sz == 2'd2) ? 2 : 3;
            end else begin
                exp_rd = (w >> sh) & mask;
                if (sgn && exp_rd > (mask >> 1)) exp_rd = exp_rd | ~mask;
            end
        end

        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        resp_cyc = -1; we_cyc = -1; we_cnt = 0; resp_cnt = 0;
        got_rd = 32'hX; got_err = 1'bX;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; we_cyc = k; end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = k;
                    got_rd   = resp_rdata;
                    got_err  = resp_err;
                end
            end
        end
        chk({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(lat));
        chk({tag, "_resp_count"}, 32'(resp_cnt), 32'd1);
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_err"}, 32'(got_err), 32'(e));
        chk({tag, "_we_count"}, 32'(we_cnt), 32'(exp_we));
        if (exp_we != 0) chk({tag, "_we_cycle"}, 32'(we_cyc), 32'(lat - 1));
        chk({tag, "_mem"}, mem[idx[3:0]], ref_mem[idx[3:0]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [8:0]  resp_mask, ready_mask;
        logic        saw;
        logic        r_we, r_sg;
        logic [1:0]  r_sz;
        logic [31:0] r_addr, r_wd;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;

        for (int i = 0; i < 16; i++) poke(i, $urandom);
        poke(4, 32'h8899_AABB);

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;

        do_op("lb_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
        chk("lb_13_const", rd, 32'hFFFF_FF88);
        do_op("lbu_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
        chk("lbu_13_const", rd, 32'h0000_0088);
        do_op("lh_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, er);
        chk("lh_10_const", rd, 32'hFFFF_AABB);
        do_op("sh_12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, rd, er);
        chk("sh_12_word", mem[4], 32'h1234_AABB);
        do_op("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("sw_10_word", mem[4], 32'hDEAD_BEEF);
        do_op("lh_11_err", 1'b0, 2'd1, 1'b1, 32'h11, 32'h0, rd, er);
        chk("lh_11_err_const", 32'(er), 32'd1);
        do_op("sz11_err", 1'b1, 2'd3, 1'b0, 32'h10, 32'h1111_2222, rd, er);
        chk("sz11_err_const", 32'(er), 32'd1);
        do_op("range_err", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er);
        chk("range_err_const", 32'(er), 32'd1);

        // sb with reset asserted during the WRITE cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_we_before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1 chk("rstwr_we_gated", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstwr_ready", 32'(req_ready), 32'd1);
        saw = resp_valid;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        chk("rstwr_no_resp", 32'(saw), 32'd0);
        chk("rstwr_word", mem[4], 32'hDEAD_BEEF);

        // Back-to-back: request held high across the first transaction
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_signed = 1'b1; req_addr = 32'h10;
        @(posedge clk);
        resp_mask = '0; ready_mask = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            resp_mask[k]  = resp_valid;
            ready_mask[k] = req_ready;
            if (resp_valid) chk("b2b_rdata", resp_rdata, 32'hFFFF_BEEF);
            if (k == 4) req_valid = 1'b0;
        end
        chk("b2b_resp_mask", 32'(resp_mask), 32'(9'b000100100));
        chk("b2b_ready_mask", 32'(ready_mask), 32'(9'b111001000));

        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_sg = 1'($urandom_range(0, 1));
            r_wd = $urandom;
            if ($urandom_range(0, 7) == 0) r_addr = 32'h1000 + $urandom_range(0, 63);
            else r_addr = $urandom_range(0, 63);
            do_op($sformatf("rnd%0d", i), r_we, r_sz, r_sg, r_addr, r_wd, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
